// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel-advance enable in, counters and strobes out.
// Latency: none, this is wiring only.
// Backpressure: ce from the consumer is the only throttle on the raster.
interface vga_timing_gen_if;
  logic        ce;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic        frame_start;
  logic [7:0]  frame_count;

  // The timing generator drives the raster and receives the enable.
  modport master (
    input  ce,
    output hcount, vcount, hsync, vsync, blank, frame_start, frame_count
  );

  // A display pipeline consumes the raster and drives the enable.
  modport slave (
    output ce,
    input  hcount, vcount, hsync, vsync, blank, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel/line counters, active-low syncs, blank, frame strobe/counter.
// Latency: every output is a register, and all outputs describe the same (hcount,vcount) point.
// Backpressure: ce=0 freezes the raster and all outputs; frame_start reads 0 while frozen.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic             vclock,
  input  logic             reset,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // All boundaries are pre-sized to the counter widths so comparisons stay
  // in 11/10 bits; H_TOTAL up to 2048 and V_TOTAL up to 1024 still fit.
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] r_hcount;
  logic [9:0]  r_vcount;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_blank;
  logic        r_frame_start;
  logic [7:0]  r_frame_count;

  logic        w_h_last;
  logic        w_v_last;
  logic [10:0] w_h_nxt;
  logic [9:0]  w_v_nxt;
  logic        w_hsync_nxt;
  logic        w_vsync_nxt;
  logic        w_blank_nxt;
  logic        w_frame_wrap;

  // Next raster position and the decodes of that position, so the sync and
  // blank registers load in the same edge as the counters (no skew).
  always_comb begin
    w_h_last     = (r_hcount == H_LAST);
    w_v_last     = (r_vcount == V_LAST);
    w_frame_wrap = w_h_last && w_v_last;

    w_h_nxt = r_hcount + 11'd1;
    w_v_nxt = r_vcount;
    if (w_h_last) begin
      w_h_nxt = '0;
      w_v_nxt = w_v_last ? '0 : (r_vcount + 10'd1);
    end

    w_hsync_nxt = !((w_h_nxt >= HS_FIRST) && (w_h_nxt <= HS_LAST));
    w_vsync_nxt = !((w_v_nxt >= VS_FIRST) && (w_v_nxt <= VS_LAST));
    w_blank_nxt = (w_h_nxt >= H_VIS) || (w_v_nxt >= V_VIS);
  end

  // Raster state: reset parks at the origin with syncs idle and no strobe;
  // a frozen cycle holds everything except the one-cycle frame strobe.
  always_ff @(posedge vclock) begin
    if (reset) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_blank       <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else if (bus.ce) begin
      r_hcount      <= w_h_nxt;
      r_vcount      <= w_v_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_blank       <= w_blank_nxt;
      r_frame_start <= w_frame_wrap;
      if (w_frame_wrap) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end else begin
      r_frame_start <= 1'b0;
    end
  end

  assign bus.hcount      = r_hcount;
  assign bus.vcount      = r_vcount;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.blank       = r_blank;
  assign bus.frame_start = r_frame_start;
  assign bus.frame_count = r_frame_count;

  // The frame strobe can only ever accompany the origin.
  a_frame_start_at_origin: assert property (
    @(posedge vclock) r_frame_start |-> (r_hcount == '0) && (r_vcount == '0)
  );

  // Counters never present a position beyond the raster.
  a_counts_in_range: assert property (
    @(posedge vclock) (r_hcount <= H_LAST) && (r_vcount <= V_LAST)
  );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one full-size instance for horizontal/ce checks,
// one reduced-raster instance (16x10) for table vectors, resets and 256-frame wrap.
module tb_vga_timing_gen;

  logic clk;
  logic rst;
  logic ce;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if bus_d ();
  vga_timing_gen_if bus_s ();
  assign bus_d.ce = ce;
  assign bus_s.ce = ce;

  // Default 1024x768 raster: H_TOTAL 1344, V_TOTAL 806.
  vga_timing_gen u_dut_default (
    .vclock (clk),
    .reset  (rst),
    .bus    (bus_d)
  );

  // Reduced raster: H 8+2+3+3 = 16 (hsync low 10..12, blank h>=8),
  // V 6+1+2+1 = 10 (vsync low 7..8, blank v>=6); 160 cycles per frame.
  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1)
  ) u_dut_small (
    .vclock (clk),
    .reset  (rst),
    .bus    (bus_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_small(input string tag, input int h, input int v, input logic hs,
                           input logic vs, input logic bl, input logic fs, input int fc);
    chk({tag, ".hcount"},      32'(bus_s.hcount),      32'(h));
    chk({tag, ".vcount"},      32'(bus_s.vcount),      32'(v));
    chk({tag, ".hsync"},       32'(bus_s.hsync),       32'(hs));
    chk({tag, ".vsync"},       32'(bus_s.vsync),       32'(vs));
    chk({tag, ".blank"},       32'(bus_s.blank),       32'(bl));
    chk({tag, ".frame_start"}, 32'(bus_s.frame_start), 32'(fs));
    chk({tag, ".frame_count"}, 32'(bus_s.frame_count), 32'(fc));
  endtask

  typedef struct {
    logic rst;
    logic ce;
    int   n;
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic bl;
    logic fs;
    int   fc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic c, input int n, input int h,
                              input int v, input logic hs, input logic vs, input logic bl,
                              input logic fs, input int fc);
    vec_t t;
    t.rst = r; t.ce = c; t.n = n; t.h = h; t.v = v;
    t.hs = hs; t.vs = vs; t.bl = bl; t.fs = fs; t.fc = fc;
    return t;
  endfunction

  // Watchdog: the whole run is ~56k cycles (~0.56 ms).
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic prev_hs;
    int   falls, rises;
    int   mh, mv, mfc, pulses, vrun;
    logic mfs;

    // Reduced-raster vectors; each applies {rst,ce} for n cycles, then compares.
    //                   rst ce  n   h  v  hs vs bl fs fc
    vecs.push_back(mk(1, 1,  3,  0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1,  1,  1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1,  6,  7, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1,  1,  8, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1,  2, 10, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1,  2, 12, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1,  1, 13, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1,  2, 15, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1,  1,  0, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  3,  0, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 64,  0, 5, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16,  0, 6, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 16,  0, 7, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1,  5,  5, 7, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 11,  0, 8, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 16,  0, 9, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 15, 15, 9, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1,  1,  0, 0, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0,  1,  0, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1,  1,  1, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 66,  3, 4, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1,  1,  0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  2,  0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1,  1,  1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0,  1,  0, 0, 1, 1, 0, 0, 0));

    // Reset hold with ce=1: origin values on every cycle.
    rst = 1'b1;
    ce  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_small($sformatf("rst_hold%0d", i), 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      chk("rst_hold.default_hcount", 32'(bus_d.hcount), 32'd0);
    end

    // Full-size horizontal line from the origin.
    rst     = 1'b0;
    prev_hs = bus_d.hsync;
    falls   = 0;
    rises   = 0;
    for (int i = 1; i <= 1344; i++) begin
      step();
      if (i == 1023) begin
        chk("hline.hcount_1023", 32'(bus_d.hcount), 32'd1023);
        chk("hline.blank_at_1023", 32'(bus_d.blank), 32'd0);
      end
      if (i == 1024) begin
        chk("hline.blank_at_1024", 32'(bus_d.blank), 32'd1);
      end
      if (prev_hs && !bus_d.hsync) begin
        falls++;
        chk("hline.hsync_fall_hcount", 32'(bus_d.hcount), 32'd1048);
      end
      if (!prev_hs && bus_d.hsync) begin
        rises++;
        chk("hline.hsync_rise_hcount", 32'(bus_d.hcount), 32'd1184);
      end
      prev_hs = bus_d.hsync;
    end
    chk("hline.wrap_hcount", 32'(bus_d.hcount), 32'd0);
    chk("hline.wrap_vcount", 32'(bus_d.vcount), 32'd1);
    chk("hline.wrap_blank",  32'(bus_d.blank),  32'd0);
    chk("hline.hsync_falls", 32'(falls), 32'd1);
    chk("hline.hsync_rises", 32'(rises), 32'd1);

    // Clock-enable freeze at (500,10) on the full-size raster.
    repeat (9 * 1344 + 500) step();
    chk("ce.pos_hcount", 32'(bus_d.hcount), 32'd500);
    chk("ce.pos_vcount", 32'(bus_d.vcount), 32'd10);
    ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("ce.frozen_hcount",      32'(bus_d.hcount),      32'd500);
      chk("ce.frozen_vcount",      32'(bus_d.vcount),      32'd10);
      chk("ce.frozen_hsync",       32'(bus_d.hsync),       32'd1);
      chk("ce.frozen_vsync",       32'(bus_d.vsync),       32'd1);
      chk("ce.frozen_blank",       32'(bus_d.blank),       32'd0);
      chk("ce.frozen_frame_start", 32'(bus_d.frame_start), 32'd0);
      chk("ce.frozen_frame_count", 32'(bus_d.frame_count), 32'd0);
    end
    ce = 1'b1;
    step();
    chk("ce.resume_hcount", 32'(bus_d.hcount), 32'd501);
    chk("ce.resume_vcount", 32'(bus_d.vcount), 32'd10);

    // Table-driven vectors on the reduced raster.
    foreach (vecs[k]) begin
      rst = vecs[k].rst;
      ce  = vecs[k].ce;
      repeat (vecs[k].n) step();
      chk_small($sformatf("vec%0d", k), vecs[k].h, vecs[k].v, vecs[k].hs, vecs[k].vs,
                vecs[k].bl, vecs[k].fs, vecs[k].fc);
    end

    // 256 full reduced frames against a raster reference, from a fresh reset.
    rst = 1'b1;
    ce  = 1'b1;
    step();
    rst    = 1'b0;
    mh     = 0;
    mv     = 0;
    mfc    = 0;
    pulses = 0;
    vrun   = 0;
    for (int c = 1; c <= 256 * 160; c++) begin
      step();
      mfs = 1'b0;
      if (mh == 15) begin
        mh = 0;
        if (mv == 9) begin
          mv  = 0;
          mfs = 1'b1;
          mfc = (mfc + 1) % 256;
        end else begin
          mv++;
        end
      end else begin
        mh++;
      end
      chk_small("frames", mh, mv, !(mh >= 10 && mh <= 12), !(mv >= 7 && mv <= 8),
                (mh >= 8) || (mv >= 6), mfs, mfc);
      if (bus_s.frame_start) pulses++;
      if (!bus_s.vsync) begin
        vrun++;
      end else if (vrun != 0) begin
        chk("frames.vsync_low_cycles", 32'(vrun), 32'd32);
        vrun = 0;
      end
      if (n_fail > 50) break;
    end
    chk("frames.pulse_count", 32'(pulses), 32'd256);
    chk("frames.final_frame_count", 32'(bus_s.frame_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_ACTIVE, 1024, visible pixels per line.
- H_FP, 24, horizontal front porch (pixels).
- H_SYNC, 136, horizontal sync width (pixels).
- H_BP, 160, horizontal back porch (pixels).
- V_ACTIVE, 768, visible lines per frame.
- V_FP, 3, vertical front porch (lines).
- V_SYNC, 6, vertical sync width (lines).
- V_BP, 29, vertical back porch (lines).
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- vclock  input  1  pixel clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ce  input  1  pixel advance enable.
- hcount  output  11  current pixel column.
- vcount  output  10  current line.
- hsync  output  1  horizontal sync, active low.
- vsync  output  1  vertical sync, active low.
- blank  output  1  high outside the visible area.
- frame_start  output  1  one-cycle pulse on entry to (0,0).
- frame_count  output  8  completed-frame counter.
REQ-003 The block SHALL use one clock (vclock); reset SHALL be synchronous and active-high.

Function
REQ-004 Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344 default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (806 default).
REQ-005 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-006 On a cycle with ce=1, hcount SHALL increment by 1; at H_TOTAL-1 it SHALL wrap to 0.
REQ-007 vcount SHALL increment only on the cycle hcount wraps; at V_TOTAL-1 it SHALL wrap to 0 on that same cycle.
REQ-008 With ce=0, hcount, vcount, hsync, vsync, blank and frame_count SHALL hold; frame_start SHALL be 0.
REQ-009 hsync SHALL be 0 exactly when the presented hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (1048..1183 default); otherwise 1.
REQ-010 vsync SHALL be 0 exactly when the presented vcount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (771..776 default), for all hcount on those lines.
REQ-011 blank SHALL be 1 exactly when the presented hcount >= H_ACTIVE or vcount >= V_ACTIVE.
REQ-012 hsync, vsync and blank SHALL always be consistent with the hcount/vcount presented in the same cycle: computed from next-count values, zero skew.
REQ-013 frame_start SHALL be 1 for exactly one cycle, in the cycle the counters first present (0,0) after wrapping from (H_TOTAL-1, V_TOTAL-1).
REQ-014 frame_count SHALL increment by 1 in the same cycle frame_start is 1 and wrap 255 -> 0.
REQ-015 Count arithmetic SHALL not overflow: 11-bit hcount and 10-bit vcount SHALL cover any H_TOTAL <= 2048 and V_TOTAL <= 1024.

Reset
REQ-016 With reset=1 at a rising edge, the next cycle SHALL present: hcount=0, vcount=0, hsync=1, vsync=1, blank=0, frame_start=0, frame_count=0, regardless of ce.
REQ-017 Reset asserted mid-frame SHALL abort the frame immediately with no frame_start pulse; counting SHALL resume from (0,0) on the first ce=1 cycle after release.

Verification
REQ-018 Reset hold: reset=1 for 5 cycles, ce=1 -> hcount=0, vcount=0, hsync=1, vsync=1, blank=0, frame_start=0, frame_count=0 throughout.
REQ-019 Horizontal timing: from (0,0) with ce=1 -> blank=0 at hcount=1023, blank=1 at 1024; hsync falls with hcount=1048 and rises with hcount=1184; wrap after 1344 cycles to hcount=0, vcount=1, blank=0.
REQ-020 Vertical and frame timing: run 1,083,264 cycles from (0,0) -> vsync=0 for exactly 8064 consecutive cycles (vcount 771..776); blank=1 for all of vcount 768..805; frame_start=1 for one cycle at return to (0,0); frame_count=1.
REQ-021 Clock enable: drop ce for 10 cycles at hcount=500, vcount=10 -> all outputs frozen at those values, frame_start=0; on ce=1 hcount resumes at 501.
REQ-022 Mid-frame reset: reset=1 for one cycle at (700,400) -> next cycle presents REQ-016 values; no frame_start pulse; frame_count=0.
REQ-023 Frame counter wrap: run 256 full frames -> frame_count steps 1..255 then 0, with exactly 256 frame_start pulses.
